// File: rtl/mc_datapath_pkg.sv
// Shared encodings and instruction-field positions for the multi-cycle MIPS datapath.
// Imported by mc_pc_unit and mc_datapath_regs.
package mc_datapath_pkg;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RSVD   = 2'b11;

  localparam logic [1:0] PCCOND_NONE = 2'b00;
  localparam logic [1:0] PCCOND_BEQ  = 2'b01;
  localparam logic [1:0] PCCOND_BNE  = 2'b10;
  localparam logic [1:0] PCCOND_RSVD = 2'b11;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int TARGET_MSB = 25;

  function automatic logic [31:0] signExt16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mc_pc_unit.sv
// Program counter with beq/bne write qualification and next-PC selection.
// Optional build macro MC_PC_ALIGN_CHECK_EN suppresses misaligned PC writes and flags them.
module mc_pc_unit
  import mc_datapath_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic [1:0]  pc_write_cond,
  input  logic [1:0]  pc_source,
  input  logic        alu_zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic        misalign_err
);

  logic        pcEn;
  logic        pcLoad;
  logic [31:0] nextPc;

  // Unconditional write dominates; the reserved condition code never writes.
  always_comb begin
    pcEn = pc_write
         | ((pc_write_cond == PCCOND_BEQ) &  alu_zero)
         | ((pc_write_cond == PCCOND_BNE) & ~alu_zero);
  end

  always_comb begin
    nextPc = pc;
    case (pc_source)
      PCSRC_ALU:    nextPc = alu_result;
      PCSRC_ALUOUT: nextPc = alu_out;
      PCSRC_JUMP:   nextPc = jump_target;
      default:      nextPc = pc;
    endcase
  end

  assign pcLoad = pcEn & (pc_source != PCSRC_RSVD);

`ifdef MC_PC_ALIGN_CHECK_EN
  logic misaligned;
  logic errQ;

  assign misaligned = pcLoad & (nextPc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc   <= RESET_PC;
      errQ <= 1'b0;
    end else if (misaligned) begin
      errQ <= 1'b1;
    end else if (pcLoad) begin
      pc <= nextPc;
    end
  end

  assign misalign_err = errQ;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (pcLoad) begin
      pc <= nextPc;
    end
  end

  assign misalign_err = 1'b0;
`endif

endmodule

// File: rtl/mc_datapath_regs.sv
// Inter-step register stage of the multi-cycle MIPS datapath (PC, IR, MDR, A, B, ALUOut).
// Build macro MC_PC_ALIGN_CHECK_EN enables the PC misalignment check inside mc_pc_unit.
module mc_datapath_regs
  import mc_datapath_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic [1:0]       pc_write_cond,
  input  logic [1:0]       pc_source,
  input  logic             ior_d,
  input  logic             ir_write,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic [31:0]      mem_rdata,
  input  logic [31:0]      rf_rdata_a,
  input  logic [31:0]      rf_rdata_b,
  output logic [31:0]      pc,
  output logic [31:0]      mem_addr,
  output logic [31:0]      ir,
  output logic [5:0]       opcode,
  output logic [5:0]       funct,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [31:0]      imm_sext,
  output logic [31:0]      jump_target,
  output logic [31:0]      mdr,
  output logic [31:0]      reg_a,
  output logic [31:0]      reg_b,
  output logic [31:0]      alu_out,
  output logic [CNT_W-1:0] instr_count,
  output logic             misalign_err
);

  mc_pc_unit #(.RESET_PC(RESET_PC)) uPcUnit (
    .clk          (clk),
    .rst          (rst),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_source    (pc_source),
    .alu_zero     (alu_zero),
    .alu_result   (alu_result),
    .alu_out      (alu_out),
    .jump_target  (jump_target),
    .pc           (pc),
    .misalign_err (misalign_err)
  );

  // IR and fetch counter only move on ir_write; the step registers sample every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir          <= '0;
      instr_count <= '0;
      mdr         <= '0;
      reg_a       <= '0;
      reg_b       <= '0;
      alu_out     <= '0;
    end else begin
      if (ir_write) begin
        ir          <= mem_rdata;
        instr_count <= instr_count + 1'b1;
      end
      mdr     <= mem_rdata;
      reg_a   <= rf_rdata_a;
      reg_b   <= rf_rdata_b;
      alu_out <= alu_result;
    end
  end

  assign mem_addr    = ior_d ? alu_out : pc;
  assign opcode      = ir[OPCODE_LSB +: 6];
  assign funct       = ir[FUNCT_LSB +: 6];
  assign rs          = ir[RS_LSB +: 5];
  assign rt          = ir[RT_LSB +: 5];
  assign rd          = ir[RD_LSB +: 5];
  assign imm_sext    = signExt16(ir[IMM_MSB:0]);
  assign jump_target = {pc[31:28], ir[TARGET_MSB:0], 2'b00};

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Self-checking bench for mc_datapath_regs: directed scenarios plus randomized cycles against a reference model.
// Expectations follow MC_PC_ALIGN_CHECK_EN when it is defined for the build.
module tb_mc_datapath_regs;

  localparam int CNT_W = 4;
`ifdef MC_PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pc_write = 1'b0;
  logic [1:0]       pc_write_cond = 2'b00;
  logic [1:0]       pc_source = 2'b00;
  logic             ior_d = 1'b0;
  logic             ir_write = 1'b0;
  logic [31:0]      alu_result = '0;
  logic             alu_zero = 1'b0;
  logic [31:0]      mem_rdata = '0;
  logic [31:0]      rf_rdata_a = '0;
  logic [31:0]      rf_rdata_b = '0;
  logic [31:0]      pc, mem_addr, ir, imm_sext, jump_target, mdr, reg_a, reg_b, alu_out;
  logic [5:0]       opcode, funct;
  logic [4:0]       rs, rt, rd;
  logic [CNT_W-1:0] instr_count;
  logic             misalign_err;

  int nTests = 0;
  int nFail  = 0;

  // Reference state
  logic [31:0]      mPc, mIr, mMdr, mA, mB, mAluOut;
  logic [CNT_W-1:0] mCnt;
  logic             mErr;

  mc_datapath_regs #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .ior_d(ior_d), .ir_write(ir_write), .alu_result(alu_result),
    .alu_zero(alu_zero), .mem_rdata(mem_rdata), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .pc(pc), .mem_addr(mem_addr), .ir(ir), .opcode(opcode), .funct(funct), .rs(rs), .rt(rt),
    .rd(rd), .imm_sext(imm_sext), .jump_target(jump_target), .mdr(mdr), .reg_a(reg_a),
    .reg_b(reg_b), .alu_out(alu_out), .instr_count(instr_count), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mPc = 32'h0; mIr = 0; mMdr = 0; mA = 0; mB = 0; mAluOut = 0; mCnt = 0; mErr = 0;
  endtask

  // Advance one clock edge and move the reference model by the same step.
  task automatic clkStep();
    logic [31:0] target;
    logic        take;
    take = pc_write || (pc_write_cond == 2'd1 && alu_zero) || (pc_write_cond == 2'd2 && !alu_zero);
    case (pc_source)
      2'd0:    target = alu_result;
      2'd1:    target = mAluOut;
      2'd2:    target = (mPc & 32'hF000_0000) | ((mIr & 32'h03FF_FFFF) * 4);
      default: begin target = mPc; take = 1'b0; end
    endcase
    if (take) begin
      if (ALIGN && (target % 4) != 0) mErr = 1'b1;
      else mPc = target;
    end
    if (ir_write) begin
      mIr  = mem_rdata;
      mCnt = mCnt + 1'b1;
    end
    mMdr = mem_rdata; mA = rf_rdata_a; mB = rf_rdata_b; mAluOut = alu_result;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    pc_write = 0; pc_write_cond = 0; pc_source = 0; ir_write = 0; ior_d = 0; alu_zero = 0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst = 1'b1;
    #7;
    rst = 1'b0;
    modelReset();
    @(posedge clk); #1;
    nTests++; if (pc !== 32'h0) begin nFail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    nTests++; if (instr_count !== '0) begin nFail++; $display("FAIL reset_cnt: got %0d want 0", instr_count); end
    // dirty the state, then reset between edges
    ir_write = 1; mem_rdata = 32'hDEAD_BEEF; pc_write = 1; alu_result = 32'h0000_0124;
    rf_rdata_a = 32'h1111_2222; rf_rdata_b = 32'h3333_4444;
    clkStep(); clkStep();
    idleInputs();
    #3;
    rst = 1'b1;
    #1;
    nTests++; if (pc !== 32'h0) begin nFail++; $display("FAIL async_reset_pc: got %h want %h", pc, 32'h0); end
    nTests++; if (ir !== 32'h0) begin nFail++; $display("FAIL async_reset_ir: got %h want %h", ir, 32'h0); end
    nTests++; if (instr_count !== '0) begin nFail++; $display("FAIL async_reset_cnt: got %0d want 0", instr_count); end
    nTests++; if ({mdr, reg_a, reg_b, alu_out} !== 128'h0) begin nFail++;
      $display("FAIL async_reset_regs: got %h %h %h %h want 0", mdr, reg_a, reg_b, alu_out); end
    nTests++; if (misalign_err !== 1'b0) begin nFail++; $display("FAIL async_reset_err: got %b want 0", misalign_err); end
    #2;
    rst = 1'b0;
    modelReset();
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    idleInputs();
    mem_rdata = 32'h2008_0005; ir_write = 1; pc_write = 1; pc_source = 2'd0; alu_result = 32'd4;
    nTests++; if (mem_addr !== 32'h0) begin nFail++; $display("FAIL fetch_addr: got %h want %h", mem_addr, 32'h0); end
    clkStep();
    idleInputs();
    nTests++; if (ir !== 32'h2008_0005) begin nFail++; $display("FAIL fetch_ir: got %h want %h", ir, 32'h2008_0005); end
    nTests++; if (opcode !== 6'h08) begin nFail++; $display("FAIL fetch_opcode: got %h want %h", opcode, 6'h08); end
    nTests++; if (rt !== 5'd8 || rs !== 5'd0) begin nFail++; $display("FAIL fetch_rs_rt: got %0d %0d want 0 8", rs, rt); end
    nTests++; if (imm_sext !== 32'd5) begin nFail++; $display("FAIL fetch_imm: got %h want %h", imm_sext, 32'd5); end
    nTests++; if (pc !== 32'd4) begin nFail++; $display("FAIL fetch_pc: got %h want %h", pc, 32'd4); end
    nTests++; if (instr_count !== 4'd1) begin nFail++; $display("FAIL fetch_cnt: got %0d want 1", instr_count); end
    mem_rdata = 32'h8C43_FFF8; ir_write = 1;
    clkStep();
    idleInputs();
    nTests++; if (imm_sext !== 32'hFFFF_FFF8) begin nFail++; $display("FAIL neg_imm: got %h want %h", imm_sext, 32'hFFFF_FFF8); end
    nTests++; if (rd !== 5'h1F || funct !== 6'h38) begin nFail++; $display("FAIL rd_funct: got %h %h want 1f 38", rd, funct); end
  endtask

  task automatic test_branch();
    idleInputs();
    alu_result = 32'h40;
    clkStep();
    // beq taken: alu_out=0x40 becomes PC
    pc_write_cond = 2'd1; pc_source = 2'd1; alu_zero = 1; alu_result = 32'h80;
    clkStep();
    nTests++; if (pc !== 32'h40) begin nFail++; $display("FAIL beq_taken: got %h want %h", pc, 32'h40); end
    alu_zero = 0;
    clkStep();
    nTests++; if (pc !== 32'h40) begin nFail++; $display("FAIL beq_not_taken: got %h want %h", pc, 32'h40); end
    pc_write_cond = 2'd2; alu_zero = 1; alu_result = 32'hC0;
    clkStep();
    nTests++; if (pc !== 32'h40) begin nFail++; $display("FAIL bne_not_taken: got %h want %h", pc, 32'h40); end
    pc_write = 1; alu_result = 32'h100;
    clkStep();
    nTests++; if (pc !== 32'hC0) begin nFail++; $display("FAIL pcwrite_dominates: got %h want %h", pc, 32'hC0); end
    pc_write = 0; alu_zero = 0; alu_result = 32'h200;
    clkStep();
    nTests++; if (pc !== 32'h100) begin nFail++; $display("FAIL bne_taken: got %h want %h", pc, 32'h100); end
    pc_write_cond = 2'd3; alu_zero = 1;
    clkStep();
    nTests++; if (pc !== 32'h100) begin nFail++; $display("FAIL cond_reserved: got %h want %h", pc, 32'h100); end
    pc_write_cond = 2'd0; pc_write = 1; pc_source = 2'd3;
    clkStep();
    nTests++; if (pc !== 32'h100) begin nFail++; $display("FAIL src_reserved: got %h want %h", pc, 32'h100); end
    idleInputs();
  endtask

  task automatic test_jump();
    idleInputs();
    pc_write = 1; pc_source = 2'd0; alu_result = 32'h1000_0004; ir_write = 1; mem_rdata = 32'h0800_0010;
    clkStep();
    idleInputs();
    alu_result = 32'h0000_0ABC;
    nTests++; if (jump_target !== 32'h1000_0040) begin nFail++; $display("FAIL jump_target: got %h want %h", jump_target, 32'h1000_0040); end
    pc_write = 1; pc_source = 2'd2;
    clkStep();
    idleInputs();
    nTests++; if (pc !== 32'h1000_0040) begin nFail++; $display("FAIL jump_pc: got %h want %h", pc, 32'h1000_0040); end
    ior_d = 1; #1;
    nTests++; if (mem_addr !== 32'h0000_0ABC) begin nFail++; $display("FAIL addr_aluout: got %h want %h", mem_addr, 32'h0000_0ABC); end
    ior_d = 0; #1;
    nTests++; if (mem_addr !== 32'h1000_0040) begin nFail++; $display("FAIL addr_pc: got %h want %h", mem_addr, 32'h1000_0040); end
  endtask

  task automatic test_align();
    logic [31:0] pcBefore;
    idleInputs();
    pcBefore = mPc;
    pc_write = 1; pc_source = 2'd0; alu_result = 32'h6;
    clkStep();
    idleInputs();
    nTests++; if (pc !== (ALIGN ? pcBefore : 32'h6)) begin nFail++;
      $display("FAIL align_pc: got %h want %h", pc, ALIGN ? pcBefore : 32'h6); end
    nTests++; if (misalign_err !== ALIGN) begin nFail++; $display("FAIL align_err: got %b want %b", misalign_err, ALIGN); end
    pc_write = 1; alu_result = 32'h20;
    clkStep();
    idleInputs();
    nTests++; if (pc !== 32'h20) begin nFail++; $display("FAIL align_next_write: got %h want %h", pc, 32'h20); end
    nTests++; if (misalign_err !== ALIGN) begin nFail++; $display("FAIL align_sticky: got %b want %b", misalign_err, ALIGN); end
    rst = 1; #2; rst = 0; modelReset();
    @(posedge clk); #1;
    nTests++; if (misalign_err !== 1'b0) begin nFail++; $display("FAIL align_clear: got %b want 0", misalign_err); end
  endtask

  task automatic test_back_to_back();
    idleInputs();
    ir_write = 1;
    for (int i = 0; i < 17; i++) begin
      mem_rdata = $urandom;
      clkStep();
    end
    idleInputs();
    nTests++; if (instr_count !== mCnt || mCnt !== 4'd1) begin nFail++;
      $display("FAIL count_wrap: got %0d want %0d", instr_count, mCnt); end
    nTests++; if (ir !== mIr) begin nFail++; $display("FAIL b2b_ir: got %h want %h", ir, mIr); end
  endtask

  task automatic test_random();
    logic [31:0] expImm;
    for (int i = 0; i < 300; i++) begin
      pc_write      = ($urandom_range(0, 3) == 0);
      pc_write_cond = 2'($urandom_range(0, 3));
      pc_source     = 2'($urandom_range(0, 3));
      ior_d         = 1'($urandom_range(0, 1));
      ir_write      = 1'($urandom_range(0, 1));
      alu_zero      = 1'($urandom_range(0, 1));
      alu_result    = $urandom;
      if ($urandom_range(0, 3) != 0) alu_result[1:0] = 2'b00;
      mem_rdata     = $urandom;
      if ($urandom_range(0, 1) == 0) mem_rdata[1:0] = 2'b00;
      rf_rdata_a    = $urandom;
      rf_rdata_b    = $urandom;
      #1;
      nTests++; if (mem_addr !== (ior_d ? mAluOut : mPc)) begin nFail++;
        $display("FAIL rnd_mem_addr[%0d]: got %h want %h", i, mem_addr, ior_d ? mAluOut : mPc); end
      clkStep();
      expImm = (mIr % 65536 >= 32768) ? (mIr % 65536) + 32'hFFFF_0000 : mIr % 65536;
      nTests++; if (pc !== mPc) begin nFail++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc, mPc); end
      nTests++; if (ir !== mIr) begin nFail++; $display("FAIL rnd_ir[%0d]: got %h want %h", i, ir, mIr); end
      nTests++; if ({mdr, reg_a, reg_b, alu_out} !== {mMdr, mA, mB, mAluOut}) begin nFail++;
        $display("FAIL rnd_step_regs[%0d]: got %h %h %h %h want %h %h %h %h", i, mdr, reg_a, reg_b, alu_out, mMdr, mA, mB, mAluOut); end
      nTests++; if (instr_count !== mCnt) begin nFail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, instr_count, mCnt); end
      nTests++; if (misalign_err !== mErr) begin nFail++; $display("FAIL rnd_err[%0d]: got %b want %b", i, misalign_err, mErr); end
      nTests++; if (imm_sext !== expImm) begin nFail++; $display("FAIL rnd_imm[%0d]: got %h want %h", i, imm_sext, expImm); end
      nTests++; if ({opcode, rs, rt, rd, funct} !== {6'(mIr / 2**26), 5'(mIr / 2**21), 5'(mIr / 2**16), 5'(mIr / 2**11), 6'(mIr)}) begin
        nFail++; $display("FAIL rnd_fields[%0d]: got %h %h %h %h %h ir %h", i, opcode, rs, rt, rd, funct, mIr); end
    end
    idleInputs();
  endtask

  initial begin
    modelReset();
    @(posedge clk); #1;
    test_reset();
    test_fetch();
    test_branch();
    test_jump();
    test_align();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
